// File: rtl/tmds_ser_pkg.sv
// Shared constants and types for the soft TMDS/LVDS serializer.
//   IDLE_WORD   : control token (C1C0 = 00) sent whenever no data word is available.
//   CLK_PATTERN : clock-lane word, first half ones, reloaded every word period.
//   ser_state_e : S_IDLE (sending idle tokens) / S_RUN (draining the FIFO).
//   word_period : number of slice cycles per parallel word.
package tmds_ser_pkg;

    localparam logic [9:0] IDLE_WORD   = 10'b1101010100;
    localparam logic [9:0] CLK_PATTERN = 10'b0000011111;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } ser_state_e;

    function automatic int unsigned word_period(input int unsigned word_width,
                                                input int unsigned bits_per_clk);
        return word_width / bits_per_clk;
    endfunction

endpackage

// File: rtl/tmds_ser_fifo.sv
// Synchronous show-ahead FIFO with occupancy count, one entry holds all channels.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset (flushes the FIFO)
//   wr_en_i/wr_data_i : write request and data; ignored while full
//   rd_en_i/rd_data_o : pop request; rd_data_o always shows the oldest entry
//   count_o           : registered occupancy 0..DEPTH
//   full_o, empty_o   : decoded from count_o
// A word written on an edge is not visible to a pop on that same edge.
module tmds_ser_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             wr, rd;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr        = wr_en_i && !full_o;
    assign rd        = rd_en_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (wr && !rd) begin
            count_d = count_q + CW'(1);
        end else if (rd && !wr) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/tmds_serializer_gen.sv
// Soft TMDS/LVDS serializer in the bit/slice clock domain.
// Words enter via s_valid_i/s_ready_o into a FIFO and are shifted out LSB-first,
// BITS_PER_CLK bits per cycle (bit 0 of each slice is the earlier bit). A clock lane
// is reloaded at every word boundary; an idle token is sent when no word is available.
// Ports:
//   clk_pixel_x5_i    : slice clock (only clock)
//   rst_i             : asynchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i : input word handshake, one word per channel
//   underflow_clr_i   : clears the sticky underflow flag (a same-edge set wins)
//   tmds_lane_o       : current slice per channel
//   tmds_clock_lane_o : current slice of the clock pattern
//   word_start_o      : high during slice 0 of every word
//   running_o         : state is S_RUN
//   underflow_o       : sticky underflow flag
// Optional: define TMDS_SER_UNDERFLOW_CNT_EN to add underflow_count_o, a saturating
// underflow event counter cleared by reset and underflow_clr_i.
module tmds_serializer_gen
    import tmds_ser_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned WORD_WIDTH   = 10,
    parameter int unsigned BITS_PER_CLK = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned START_LEVEL  = 2
) (
    input  logic                                      clk_pixel_x5_i,
    input  logic                                      rst_i,
    input  logic                                      s_valid_i,
    output logic                                      s_ready_o,
    input  logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0]   s_data_i,
    input  logic                                      underflow_clr_i,
    output logic [NUM_CHANNELS-1:0][BITS_PER_CLK-1:0] tmds_lane_o,
    output logic [BITS_PER_CLK-1:0]                   tmds_clock_lane_o,
    output logic                                      word_start_o,
    output logic                                      running_o,
    output logic                                      underflow_o
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                               underflow_count_o
`endif
);

    localparam int unsigned N  = word_period(WORD_WIDTH, BITS_PER_CLK);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DW = NUM_CHANNELS * WORD_WIDTH;
    localparam logic [PW-1:0] LastPhase = PW'(N - 1);
    // Non-10-bit widths take the low bits of the token and a half-ones clock word.
    localparam logic [WORD_WIDTH-1:0] IdleWord = WORD_WIDTH'(IDLE_WORD);
    localparam logic [WORD_WIDTH-1:0] HalfOnes =
        {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - WORD_WIDTH / 2);
    localparam logic [WORD_WIDTH-1:0] ClkWord =
        (WORD_WIDTH == 10) ? WORD_WIDTH'(CLK_PATTERN) : HalfOnes;

    ser_state_e                             state_q, state_d;
    logic [PW-1:0]                          phase_q, phase_d;
    logic                                   word_start_q, word_start_d;
    logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] sh_q, sh_d;
    logic [WORD_WIDTH-1:0]                  clk_q, clk_d;
    logic                                   underflow_q, underflow_d;
    logic                                   boundary, pop, uf_set;
    logic [DW-1:0]                          fifo_wdata, fifo_rdata;
    logic [CW-1:0]                          fifo_count;
    logic                                   fifo_full, fifo_empty;

    assign fifo_wdata = s_data_i;

    tmds_ser_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_pixel_x5_i),
        .rst_i     (rst_i),
        .wr_en_i   (s_valid_i),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign boundary = (phase_q == LastPhase);

    always_comb begin
        state_d      = state_q;
        phase_d      = boundary ? '0 : phase_q + PW'(1);
        word_start_d = (phase_d == '0);
        clk_d        = clk_q >> BITS_PER_CLK;
        pop          = 1'b0;
        uf_set       = 1'b0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            sh_d[c] = sh_q[c] >> BITS_PER_CLK;
        end
        if (boundary) begin
            clk_d = ClkWord;
            unique case (state_q)
                S_IDLE: begin
                    // The start decision loads idle now; data follows one word later.
                    sh_d = {NUM_CHANNELS{IdleWord}};
                    if (fifo_count >= CW'(START_LEVEL)) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        sh_d = fifo_rdata;
                    end else begin
                        sh_d    = {NUM_CHANNELS{IdleWord}};
                        uf_set  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign underflow_d = uf_set | (underflow_q & ~underflow_clr_i);

    always_ff @(posedge clk_pixel_x5_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            phase_q      <= LastPhase;
            word_start_q <= 1'b0;
            sh_q         <= '0;
            clk_q        <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            word_start_q <= word_start_d;
            sh_q         <= sh_d;
            clk_q        <= clk_d;
            underflow_q  <= underflow_d;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            tmds_lane_o[c] = sh_q[c][BITS_PER_CLK-1:0];
        end
    end

    assign tmds_clock_lane_o = clk_q[BITS_PER_CLK-1:0];
    assign word_start_o      = word_start_q;
    assign running_o         = (state_q == S_RUN);
    assign underflow_o       = underflow_q;
    assign s_ready_o         = ~fifo_full;

`ifdef TMDS_SER_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = underflow_clr_i ? '0 : uf_cnt_q;
        if (uf_set && (uf_cnt_d != 16'hFFFF)) uf_cnt_d = uf_cnt_d + 16'd1;
    end

    always_ff @(posedge clk_pixel_x5_i or posedge rst_i) begin
        if (rst_i) uf_cnt_q <= '0;
        else       uf_cnt_q <= uf_cnt_d;
    end

    assign underflow_count_o = uf_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_serializer_gen.sv
// Directed bench: a 3-lane 10-bit DDR instance and a 1-lane 8-bit SDR instance.
module tb_tmds_serializer_gen;

    localparam logic [9:0] IDLE10 = 10'b1101010100;
    localparam logic [9:0] CLK10  = 10'b0000011111;
    localparam logic [7:0] IDLE8  = 8'h54;
    localparam logic [7:0] CLK8   = 8'h0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 3 x 10-bit, 2 bits per clock
    logic             rst, s_valid, s_ready, uf_clr, ws, running, uf;
    logic [2:0][9:0]  s_data;
    logic [2:0][1:0]  lane;
    logic [1:0]       clane;
    // 1 x 8-bit, 1 bit per clock
    logic             rst1, v1, rdy1, ws1, run1, uf1;
    logic [0:0][7:0]  d1;
    logic [0:0][0:0]  lane1;
    logic [0:0]       clane1;
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
    logic [15:0]      ucnt, ucnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tmds_serializer_gen #(
        .NUM_CHANNELS (3), .WORD_WIDTH (10), .BITS_PER_CLK (2),
        .FIFO_DEPTH (4), .START_LEVEL (2)
    ) u_dut (
        .clk_pixel_x5_i    (clk),
        .rst_i             (rst),
        .s_valid_i         (s_valid),
        .s_ready_o         (s_ready),
        .s_data_i          (s_data),
        .underflow_clr_i   (uf_clr),
        .tmds_lane_o       (lane),
        .tmds_clock_lane_o (clane),
        .word_start_o      (ws),
        .running_o         (running),
        .underflow_o       (uf)
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
        ,
        .underflow_count_o (ucnt)
`endif
    );

    tmds_serializer_gen #(
        .NUM_CHANNELS (1), .WORD_WIDTH (8), .BITS_PER_CLK (1),
        .FIFO_DEPTH (4), .START_LEVEL (1)
    ) u_dut1 (
        .clk_pixel_x5_i    (clk),
        .rst_i             (rst1),
        .s_valid_i         (v1),
        .s_ready_o         (rdy1),
        .s_data_i          (d1),
        .underflow_clr_i   (1'b0),
        .tmds_lane_o       (lane1),
        .tmds_clock_lane_o (clane1),
        .word_start_o      (ws1),
        .running_o         (run1),
        .underflow_o       (uf1)
`ifdef TMDS_SER_UNDERFLOW_CNT_EN
        ,
        .underflow_count_o (ucnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [2:0][9:0] mk3(input logic [9:0] w);
        logic [2:0][9:0] r;
        for (int c = 0; c < 3; c++) r[c] = w + 10'(c * 'h111);
        return r;
    endfunction

    task automatic wait_ws();
        int n = 0;
        while (!ws && n < 12) begin
            tick();
            n++;
        end
        if (!ws) check("word_start_timeout", 32'(ws), 32'd1);
    endtask

    // Reassemble one word per lane, starting at the next slice 0.
    task automatic get_word(output logic [2:0][9:0] w, output logic [9:0] cw,
                            output logic r, output logic u);
        wait_ws();
        r = running;
        u = uf;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) w[c][k*2 +: 2] = lane[c];
            cw[k*2 +: 2] = clane;
            tick();
        end
    endtask

    task automatic expect_word(input string tag, input logic [2:0][9:0] exp,
                               input logic exp_run, input logic exp_uf);
        logic [2:0][9:0] w;
        logic [9:0]      cw;
        logic            r, u;
        get_word(w, cw, r, u);
        check({tag, "_data"}, 32'(w), 32'(exp));
        check({tag, "_clk"}, 32'(cw), 32'(CLK10));
        check({tag, "_running"}, 32'(r), 32'(exp_run));
        check({tag, "_underflow"}, 32'(u), 32'(exp_uf));
    endtask

    task automatic push(input logic [9:0] w);
        s_valid = 1'b1;
        s_data  = mk3(w);
        tick();
    endtask

    task automatic expect_word1(input string tag, input logic [7:0] exp,
                                input logic exp_run, input logic exp_uf);
        logic [7:0] w, cw;
        logic       r, u;
        int         n = 0;
        while (!ws1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ws"}, 32'(ws1), 32'd1);
        r = run1;
        u = uf1;
        for (int k = 0; k < 8; k++) begin
            w[k]  = lane1[0][0];
            cw[k] = clane1[0];
            tick();
        end
        check({tag, "_data"}, 32'(w), 32'(exp));
        check({tag, "_clk"}, 32'(cw), 32'(CLK8));
        check({tag, "_running"}, 32'(r), 32'(exp_run));
        check({tag, "_underflow"}, 32'(u), 32'(exp_uf));
        // next word must start exactly 8 cycles after the previous one
        check({tag, "_period8"}, 32'(ws1), 32'd1);
    endtask

    initial begin
        logic [2:0][9:0] w;
        logic [9:0]      cw;
        logic            r, u, found;
        logic [5:0]      rdy_seen;
        int              acc;

        rst = 1'b1; rst1 = 1'b1; s_valid = 1'b0; s_data = '0; uf_clr = 1'b0;
        v1 = 1'b0; d1 = '0;
        #12;
        check("rst_lane", 32'(lane), 32'd0);
        check("rst_clock_lane", 32'(clane), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_word_start", 32'(ws), 32'd0);
        check("rst_underflow", 32'(uf), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        rst1 = 1'b0;

        // idle after reset
        expect_word("idle0", {3{IDLE10}}, 1'b0, 1'b0);
        expect_word("idle1", {3{IDLE10}}, 1'b0, 1'b0);

        // three words pushed from slice 0: run decision at the next boundary
        wait_ws();
        push(10'h3FF);
        push(10'h000);
        push(10'h155);
        s_valid = 1'b0;
        expect_word("run_idle", {3{IDLE10}}, 1'b1, 1'b0);
        expect_word("w3ff", mk3(10'h3FF), 1'b1, 1'b0);
        expect_word("w000", mk3(10'h000), 1'b1, 1'b0);
        expect_word("w155", mk3(10'h155), 1'b1, 1'b0);
        expect_word("drain_idle", {3{IDLE10}}, 1'b0, 1'b1);

        // sticky flag, then clear
        check("uf_sticky", 32'(uf), 32'd1);
        uf_clr = 1'b1;
        tick();
        uf_clr = 1'b0;
        check("uf_cleared", 32'(uf), 32'd0);

        // reset mid-word at P = 2 while running with words still queued
        wait_ws();
        push(10'h0AA);
        push(10'h1CC);
        push(10'h2F0);
        s_valid = 1'b0;
        expect_word("run_idle2", {3{IDLE10}}, 1'b1, 1'b0);
        wait_ws();
        tick();
        tick();
        check("pre_rst_running", 32'(running), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_lane", 32'(lane), 32'd0);
        check("mid_rst_clock_lane", 32'(clane), 32'd0);
        check("mid_rst_running", 32'(running), 32'd0);
        check("mid_rst_ready", 32'(s_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("restart_word_start", 32'(ws), 32'd1);
        check("restart_clock_slice0", 32'(clane), 32'd3);
        expect_word("post_rst_idle0", {3{IDLE10}}, 1'b0, 1'b0);
        expect_word("post_rst_idle1", {3{IDLE10}}, 1'b0, 1'b0);

        // six back-to-back offers, refused ones are not retried
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid     = 1'b1;
            s_data      = mk3(10'(1 << i));
            rdy_seen[i] = s_ready;
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0;
        check("fill_accepts", 32'(acc), 32'd4);
        check("fill_ready_4th", 32'(rdy_seen[3]), 32'd1);
        check("fill_ready_5th", 32'(rdy_seen[4]), 32'd0);
        found = 1'b0;
        for (int n = 0; n < 6 && !found; n++) begin
            get_word(w, cw, r, u);
            if (w[0] != IDLE10) found = 1'b1;
        end
        check("fill_first_found", 32'(found), 32'd1);
        check("fill_w1", 32'(w), 32'(mk3(10'h001)));
        expect_word("fill_w2", mk3(10'h002), 1'b1, 1'b0);
        expect_word("fill_w4", mk3(10'h004), 1'b1, 1'b0);
        expect_word("fill_w8", mk3(10'h008), 1'b1, 1'b0);
        expect_word("fill_end_idle", {3{IDLE10}}, 1'b0, 1'b1);

        // SDR 8-bit instance: 0xA5 -> serial 1,0,1,0,0,1,0,1
        while (!ws1) tick();
        v1 = 1'b1;
        d1 = 8'hA5;
        tick();
        v1 = 1'b0;
        expect_word1("sdr_run_idle", IDLE8, 1'b1, 1'b0);
        expect_word1("sdr_a5", 8'hA5, 1'b1, 1'b0);
        expect_word1("sdr_drain_idle", IDLE8, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
